// File: rtl/kamus_mem_arbiter_pkg.sv
// Shared types for the kamus memory arbiter: access widths, FSM states and owners.
package kamus_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_W_B = 2'b00,
        MEM_W_H = 2'b01,
        MEM_W_W = 2'b10
    } mem_width_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP,
        ARB_ERR
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } arb_owner_e;

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational LSU lane logic: byte enables, store replication, load extension and
// misalignment detection.
module kamus_lsu_align
    import kamus_mem_arbiter_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = rdata_i >> {addr_lo_i, 3'b000};
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = shifted;
        misaligned_o = 1'b0;
        case (width_i)
            MEM_W_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            MEM_W_H: begin
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
                misaligned_o = addr_lo_i[0];
            end
            MEM_W_W: begin
                misaligned_o = |addr_lo_i;
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/kamus_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU, with LSU
// priority and a fetch starvation guard.
module kamus_mem_arbiter
    import kamus_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_width_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_misaligned_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    arb_state_e      state_q;
    arb_owner_e      owner_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic            unsigned_q;
    logic [1:0]      width_q;
    logic [CntW-1:0] starve_q;

    logic        lsu_sel;
    logic        in_req;
    logic        resp_v;
    logic [1:0]  al_width;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;

    assign lsu_sel = lsu_req_i && !((starve_q == CntW'(STARVE_MAX)) && if_req_i);

    // In idle the aligner checks the live LSU request; afterwards it works on the latches.
    assign al_width   = (state_q == ARB_IDLE) ? lsu_width_i     : width_q;
    assign al_addr_lo = (state_q == ARB_IDLE) ? lsu_addr_i[1:0] : addr_q[1:0];

    kamus_lsu_align u_align (
        .width_i      (al_width),
        .addr_lo_i    (al_addr_lo),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .rdata_i      (mem_rdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            width_q    <= '0;
            starve_q   <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (lsu_sel) begin
                        owner_q    <= OWN_LSU;
                        addr_q     <= lsu_addr_i;
                        we_q       <= lsu_we_i;
                        width_q    <= lsu_width_i;
                        unsigned_q <= lsu_unsigned_i;
                        wdata_q    <= lsu_wdata_i;
                        state_q    <= al_misaligned ? ARB_ERR : ARB_REQ;
                    end else if (if_req_i) begin
                        owner_q    <= OWN_IF;
                        addr_q     <= if_addr_i;
                        we_q       <= 1'b0;
                        width_q    <= MEM_W_W;
                        unsigned_q <= 1'b0;
                        wdata_q    <= '0;
                        state_q    <= ARB_REQ;
                    end
                    if (!if_req_i || !lsu_sel) begin
                        starve_q <= '0;
                    end else if (starve_q != CntW'(STARVE_MAX)) begin
                        starve_q <= starve_q + CntW'(1);
                    end
                end
                ARB_REQ:  if (mem_gnt_i) state_q <= ARB_RESP;
                ARB_RESP: if (mem_rvalid_i) state_q <= ARB_IDLE;
                ARB_ERR:  state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        in_req           = (state_q == ARB_REQ);
        resp_v           = (state_q == ARB_RESP) && mem_rvalid_i;
        mem_req_o        = in_req;
        mem_addr_o       = in_req ? {addr_q[31:2], 2'b00} : '0;
        mem_we_o         = in_req && we_q;
        mem_be_o         = !in_req ? 4'b0000 : (owner_q == OWN_IF) ? 4'b1111 : al_be;
        mem_wdata_o      = (in_req && owner_q == OWN_LSU) ? al_wdata : '0;
        if_gnt_o         = in_req && mem_gnt_i && (owner_q == OWN_IF);
        lsu_gnt_o        = (in_req && mem_gnt_i && (owner_q == OWN_LSU)) || (state_q == ARB_ERR);
        lsu_misaligned_o = (state_q == ARB_ERR);
        if_rvalid_o      = resp_v && (owner_q == OWN_IF);
        if_rdata_o       = if_rvalid_o ? mem_rdata_i : '0;
        lsu_rvalid_o     = resp_v && (owner_q == OWN_LSU);
        lsu_rdata_o      = lsu_rvalid_o ? al_rdata : '0;
    end

endmodule

// File: doc/kamus_mem_arbiter.md
# kamus_mem_arbiter

Shares a single-ported unified memory between the instruction fetch stage (IF) and the load/store unit (LSU) of the kamus core. It arbitrates with LSU priority and a starvation guard for fetch, and sequences exactly one outstanding memory transaction at a time. For the LSU it generates byte enables, replicates store data and sign/zero-extends load data according to `mem_width_e`. Misaligned or invalid-width LSU accesses are rejected without touching memory.

## Interface
Parameters:
- `STARVE_MAX`, default 4: maximum consecutive LSU grants while `if_req_i` is high; the next arbitration then goes to IF.

Ports:
- `clk_i` in 1: core clock.
- `rst_i` in 1: synchronous, active-high reset. Single clock domain.
- `if_req_i` in 1: fetch request; `if_addr_i` must be held stable until `if_gnt_o`.
- `if_addr_i` in 32: fetch address; bits [1:0] are ignored.
- `if_gnt_o` out 1: fetch request accepted by memory.
- `if_rvalid_o` out 1: fetch data valid.
- `if_rdata_o` out 32: fetched word.
- `lsu_req_i` in 1: LSU request; all `lsu_*` inputs must be held stable until `lsu_gnt_o`.
- `lsu_addr_i` in 32: byte address.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_width_i` in 2: access width, `mem_width_e` (B/H/W).
- `lsu_unsigned_i` in 1: zero-extend loads (LBU/LHU).
- `lsu_wdata_i` in 32: store data, right-aligned.
- `lsu_gnt_o` out 1: LSU request accepted or rejected.
- `lsu_misaligned_o` out 1: qualifies `lsu_gnt_o`; the request was rejected and no access was made.
- `lsu_rvalid_o` out 1: load data valid, or store completed.
- `lsu_rdata_o` out 32: extended load data.
- `mem_req_o` out 1: memory request.
- `mem_addr_o` out 32: word-aligned address ([1:0] = 0).
- `mem_we_o` out 1: write enable.
- `mem_be_o` out 4: byte enables.
- `mem_wdata_o` out 32: lane-replicated store data.
- `mem_gnt_i` in 1: memory accepted the request.
- `mem_rvalid_i` in 1: response valid, for both reads and writes.
- `mem_rdata_i` in 32: read word.

## Operation
State machine `ARB_IDLE`, `ARB_REQ`, `ARB_RESP`, `ARB_ERR`.
- **ARB_IDLE**: if any request is pending, select an owner and latch its address, we, width, unsigned flag and wdata.
  - Owner is the LSU if `lsu_req_i`, unless the starvation counter equals `STARVE_MAX` and `if_req_i` is high.
  - An LSU access is misaligned when: H with addr[0]=1; W with addr[1:0]≠0; or width=2'b11. Misaligned goes to `ARB_ERR`; otherwise go to `ARB_REQ`.
- **ARB_REQ**: `mem_req_o`=1 with the latched fields. On `mem_gnt_i`, pulse the owner's `*_gnt_o` in the same cycle and go to `ARB_RESP`.
- **ARB_RESP**: wait for `mem_rvalid_i`. In that cycle, drive the owner's `*_rvalid_o`=1 and `*_rdata_o` combinationally from `mem_rdata_i`, then go to `ARB_IDLE`.
- **ARB_ERR**: `lsu_gnt_o`=1 and `lsu_misaligned_o`=1 for one cycle; no `lsu_rvalid_o`. Go to `ARB_IDLE`.
- **Starvation counter**:
  - Increments on each LSU selection while `if_req_i`=1, saturating at `STARVE_MAX`.
  - Clears on each IF selection, and in any `ARB_IDLE` cycle with `if_req_i`=0.
- **Byte enables**:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
  - IF: 4'b1111, we=0.
- **Store data**: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
- **Load data**: shift = `mem_rdata_i` >> (8·addr[1:0]). Take the low 8/16/32 bits per width, then sign- or zero-extend per the latched unsigned flag. IF data passes through unmodified.

## Timing
- **Reset values**: all outputs 0, state `ARB_IDLE`, counter 0, latches 0.
- **Reset mid-transaction**: return to `ARB_IDLE`. A `mem_rvalid_i` arriving after reset with no outstanding request is ignored (no rvalid to either side).
- **Latency**:
  - Request seen in ARB_IDLE at cycle N → `mem_req_o` at N+1.
  - Gnt at the first cycle ≥N+1 with `mem_gnt_i`.
  - rvalid at the first cycle after the grant with `mem_rvalid_i`.
  - Minimum request-to-data: 2 cycles.
  - Error path: `lsu_gnt_o` at N+1.
- **Idle cycle**: one `ARB_IDLE` cycle separates consecutive transactions; no back-to-back issue.
- **`mem_rvalid_i` outside ARB_RESP**: ignored.
- **`mem_req_o` stability**: `mem_req_o` and its fields stay stable from assertion until `mem_gnt_i`.
- **Simultaneous requests**: when `if_req_i` and `lsu_req_i` are both high in ARB_IDLE, arbitration follows the priority and counter rule. The loser sees no gnt and must keep its request held.

## Structure
- Shared package additions: `arb_state_e`, `arb_owner_e {OWN_IF, OWN_LSU}`. Reuse `mem_width_e` from the package.
- Sub-module `kamus_lsu_align`, purely combinational: computes byte enables, store-data replication, load extraction/extension, and the misaligned flag from width, addr[1:0], unsigned flag and data. The arbiter instantiates it once.

## Test plan
- **LW, no contention**: LSU LW @0x104, gnt at once, rvalid 1 cycle later with rdata 0xDEADBEEF → `mem_be_o`=4'hF, `mem_addr_o`=0x104, `lsu_rvalid_o`=1, `lsu_rdata_o`=0xDEADBEEF; `if_*` outputs stay quiet.
- **Sub-word loads**: LB @0x103 with rdata 0x80112233 → be=4'b1000, `lsu_rdata_o`=0xFFFFFF80. Same access as LBU → 0x00000080. LH @0x102 → 0xFFFF8011.
- **Stores**: SB @0x101, wdata 0x000000AB → be=4'b0010, `mem_wdata_o`=0xABABABAB, `mem_we_o`=1. SH @0x102 → be=4'b1100. `lsu_rvalid_o` pulses on the write response.
- **Misaligned**: LW @0x102, and SH @0x101 → `lsu_gnt_o`=`lsu_misaligned_o`=1 one cycle after the request; `mem_req_o` never asserted.
- **Starvation**: `STARVE_MAX`=4, both requests held continuously → grant order LSU, LSU, LSU, LSU, IF, LSU, …
- **Stall and reset**: `mem_gnt_i` held low for 5 cycles → `mem_req_o` and fields stable throughout. Then `rst_i` asserted during ARB_RESP → all outputs 0 next cycle; a subsequent stray `mem_rvalid_i` produces no rvalid on either side.
